// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter. Fetch (if_*) and data (dm_*) share a single memory port, with one transaction outstanding at a time.
// Contested grants use data priority with a fetch starvation guard. Defining MEM_ARB_RR_EN selects round-robin arbitration instead.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          if_req,
  input  logic          if_we,
  input  logic [AW-1:0] if_addr,
  input  logic [DW-1:0] if_wdata,
  output logic          if_rdy,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_rdy,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          m_proc_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_mem_rdy,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_valid,
  output logic          busy,
  output logic          timeout_err,
  output logic [1:0]    fsm_state
);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees rdy=1, and the request transfers
  // on the edge where req&rdy=1. The memory side accepts on proc_req&mem_rdy and returns exactly one valid per accept.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t          state, state_nxt;
  logic            owner;          // 0 = fetch, 1 = data
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [CW-1:0]   wait_cnt;
  logic            grant_if, grant_dm;
  logic            wait_last;

`ifdef MEM_ARB_RR_EN
  logic            last_owner;
`else
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  logic [SW-1:0]   starve_cnt;
`endif

  assign wait_last = (TIMEOUT != 0) && (wait_cnt == CW'(TO_LAST));
  assign fsm_state = state;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE) begin
      if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
        if (last_owner) grant_if = 1'b1;
        else            grant_dm = 1'b1;
`else
        if (starve_cnt == SW'(STARVE_MAX)) grant_if = 1'b1;
        else                               grant_dm = 1'b1;
`endif
      end else begin
        grant_if = if_req;
        grant_dm = dm_req;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_if || grant_dm) state_nxt = ISSUE;
      ISSUE:   if (m_mem_rdy) state_nxt = WAIT;
      WAIT:    if (m_valid || wait_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner  <= 1'b0;
`else
      starve_cnt  <= '0;
`endif
    end else begin
      // Valid wins over a timeout landing in the same cycle.
      timeout_err <= (state == WAIT) && !m_valid && wait_last;
      if (grant_if || grant_dm) begin
        owner     <= grant_dm;
        lat_we    <= grant_dm ? dm_we    : if_we;
        lat_addr  <= grant_dm ? dm_addr  : if_addr;
        lat_wdata <= grant_dm ? dm_wdata : if_wdata;
`ifdef MEM_ARB_RR_EN
        last_owner <= grant_dm;
`else
        if (grant_if)
          starve_cnt <= '0;
        else if (if_req && starve_cnt < SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
`endif
      end
      if (state == ISSUE && m_mem_rdy)
        wait_cnt <= '0;
      else if (state == WAIT && !wait_last)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    if_rdy     = grant_if;
    dm_rdy     = grant_dm;
    busy       = (state != IDLE);
    m_proc_req = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    if_valid   = 1'b0;
    dm_valid   = 1'b0;
    if_rdata   = '0;
    dm_rdata   = '0;
    if (state == ISSUE) begin
      m_proc_req = 1'b1;
      m_we       = lat_we;
      m_addr     = lat_addr;
      m_wdata    = lat_wdata;
    end
    if (state == WAIT && m_valid) begin
      if (owner) begin
        dm_valid = 1'b1;
        dm_rdata = m_rdata;
      end else begin
        if_valid = 1'b1;
        if_rdata = m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed requests, a scripted memory responder,
// and a scoreboard that matches memory-side requests and requester responses against expected queues.
module tb_mem_port_arbiter;

  logic        CLK, RST;
  logic        if_req, if_we, if_rdy, if_valid;
  logic [31:0] if_addr, if_wdata, if_rdata;
  logic        dm_req, dm_we, dm_rdy, dm_valid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        m_proc_req, m_we, m_mem_rdy, m_valid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy, timeout_err;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [64:0] exp_mem_q[$];   // {we, addr, wdata}
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] mem[logic [31:0]];

  int stall_req    = 0;
  int resp_delay   = 0;
  bit mem_hang     = 0;
  bit inject_valid = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_rdy(if_rdy), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdy(dm_rdy), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .m_proc_req(m_proc_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_mem_rdy(m_mem_rdy), .m_rdata(m_rdata), .m_valid(m_valid),
    .busy(busy), .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // ---------------- memory responder ----------------
  initial begin : mem_model
    bit          s_acc, s_rst, s_stalled, pend;
    logic [31:0] s_data;
    int          stall_cnt, dly;
    m_mem_rdy = 1'b1; m_valid = 1'b0; m_rdata = '0;
    pend = 0; stall_cnt = 0; dly = 0; s_data = '0;
    forever begin
      @(negedge CLK);
      s_acc     = m_proc_req && m_mem_rdy;
      s_stalled = m_proc_req && !m_mem_rdy;
      s_rst     = RST;
      if (s_acc) begin
        s_data = m_we ? 32'h0 : mem_rd(m_addr);
        if (m_we) mem[m_addr] = m_wdata;
      end
      @(posedge CLK); #1;
      if (s_acc) stall_cnt = 0;
      else if (s_stalled) stall_cnt++;
      m_mem_rdy = (stall_cnt >= stall_req);
      m_valid   = inject_valid;
      m_rdata   = inject_valid ? 32'h0BAD0BAD : 32'h0;
      if (s_rst || mem_hang) pend = 0;
      else begin
        if (s_acc) begin pend = 1; dly = resp_delay; end
        if (pend) begin
          if (dly == 0) begin m_valid = 1'b1; m_rdata = s_data; pend = 0; end
          else dly--;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [64:0] e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        chk("one_rdy", 64'(if_rdy && dm_rdy), 0);
        chk("one_valid", 64'(if_valid && dm_valid), 0);
        if (m_proc_req && m_mem_rdy) begin
          if (exp_mem_q.size() == 0) chk("mem_unexpected_req", 64'(m_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_mem_q.pop_front();
            chk("mem_we", 64'(m_we), 64'(e[64]));
            chk("mem_addr", 64'(m_addr), 64'(e[63:32]));
            chk("mem_wdata", 64'(m_wdata), 64'(e[31:0]));
          end
        end
        if (if_valid) begin
          if (exp_if_q.size() == 0) chk("if_unexpected_valid", 64'(if_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("if_rdata", 64'(if_rdata), 64'(exp_if_q.pop_front()));
        end else chk("if_rdata_idle", 64'(if_rdata), 0);
        if (dm_valid) begin
          if (exp_dm_q.size() == 0) chk("dm_unexpected_valid", 64'(dm_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("dm_rdata", 64'(dm_rdata), 64'(exp_dm_q.pop_front()));
        end else chk("dm_rdata_idle", 64'(dm_rdata), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit port_dm, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit seen;
    seen = 0;
    @(posedge CLK); #1;
    if (port_dm) begin dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
    else         begin if_req = 1; if_we = we; if_addr = addr; if_wdata = wdata; end
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge CLK);
      seen = port_dm ? dm_rdy : if_rdy;
    end
    if (!seen) chk("rdy_wait_expired", 0, 1);
    @(posedge CLK); #1;
    if (port_dm) begin dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; end
    else         begin if_req = 0; if_we = 0; if_addr = '0; if_wdata = '0; end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge CLK);
      done = !busy;
    end
    if (!done) chk("idle_wait_expired", 0, 1);
  endtask

  task automatic pulse_valid_expect_drop(input string name);
    @(negedge CLK); inject_valid = 1;
    @(negedge CLK);
    chk(name, 64'({if_valid, dm_valid}), 0);
    inject_valid = 0;
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 RST = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int  g;
    bit  is_if;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'hCAFEF00D;
    RST = 1;
    if_req = 0; if_we = 0; if_addr = '0; if_wdata = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 0;

    // reset state
    @(negedge CLK);
    chk("reset_outputs", 64'(|{if_rdy, if_valid, if_rdata, dm_rdy, dm_valid, dm_rdata,
                               m_proc_req, m_we, m_addr, m_wdata, busy, timeout_err}), 0);
    chk("reset_state", 64'(fsm_state), 0);

    // single fetch read with cycle-accurate latency
    exp_mem_q.push_back({1'b0, 32'h100, 32'h0});
    exp_if_q.push_back(32'hDEADBEEF);
    @(posedge CLK); #1 if_req = 1; if_addr = 32'h100;
    @(negedge CLK);
    chk("single_if_rdy", 64'(if_rdy), 1);
    chk("single_dm_rdy", 64'(dm_rdy), 0);
    @(posedge CLK); #1 if_req = 0; if_addr = '0;
    @(negedge CLK);
    chk("single_proc_req", 64'(m_proc_req), 1);
    chk("single_addr", 64'(m_addr), 64'h100);
    chk("single_if_rdy_off", 64'(if_rdy), 0);
    @(negedge CLK);
    chk("single_if_valid", 64'(if_valid), 1);
    chk("single_dm_valid", 64'(dm_valid), 0);
    @(negedge CLK);
    chk("single_back_idle", 64'(busy), 0);

    // backpressure: data write stalled 5 cycles while fetch waits
    @(negedge CLK); stall_req = 5;
    exp_mem_q.push_back({1'b1, 32'h600, 32'hA5A5_5A5A});
    exp_dm_q.push_back(32'h0);
    exp_mem_q.push_back({1'b0, 32'h700, 32'h0});
    exp_if_q.push_back(32'h0);
    issue(1, 1, 32'h600, 32'hA5A5_5A5A);
    if_req = 1; if_addr = 32'h700;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_proc_req", 64'(m_proc_req), 1);
      chk("bp_addr", 64'(m_addr), 64'h600);
      chk("bp_wdata", 64'(m_wdata), 64'hA5A5_5A5A);
      chk("bp_busy", 64'(busy), 1);
      chk("bp_no_rdy", 64'({if_rdy, dm_rdy}), 0);
    end
    stall_req = 0;
    g = 0;
    for (int i = 0; i < 64 && g == 0; i++) begin
      @(negedge CLK);
      if (if_rdy) g = 1;
    end
    chk("bp_if_granted_after", 64'(g), 1);
    @(posedge CLK); #1 if_req = 0; if_addr = '0;
    wait_idle();

    // timeout: memory never answers
    @(negedge CLK); mem_hang = 1;
    exp_mem_q.push_back({1'b0, 32'h400, 32'h0});
    issue(1, 0, 32'h400, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      chk($sformatf("to_err_c%0d", i), 64'(timeout_err), 64'(i == 10));
      if (i == 9)  chk("to_busy_last_wait", 64'(busy), 1);
      if (i == 10) chk("to_back_idle", 64'(busy), 0);
    end
    pulse_valid_expect_drop("to_late_valid_dropped");

    // reset while waiting
    exp_mem_q.push_back({1'b0, 32'h500, 32'h0});
    issue(1, 0, 32'h500, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_in_wait", 64'(fsm_state), 2);
    apply_reset();
    @(negedge CLK);
    chk("rst_outputs", 64'(|{if_rdy, if_valid, if_rdata, dm_rdy, dm_valid, dm_rdata,
                             m_proc_req, m_we, m_addr, m_wdata, busy, timeout_err}), 0);
    pulse_valid_expect_drop("rst_late_valid_dropped");
    @(negedge CLK); mem_hang = 0;
    exp_mem_q.push_back({1'b0, 32'h100, 32'h0});
    exp_dm_q.push_back(32'hDEADBEEF);
    issue(1, 0, 32'h100, 32'h0);
    wait_idle();

    // contention: both ports held high for six grants
    apply_reset();
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
      is_if = (i % 2 == 1);
`else
      is_if = (i == 4);
`endif
      if (is_if) begin
        exp_mem_q.push_back({1'b0, 32'h200, 32'h0});
        exp_if_q.push_back(32'hCAFEF00D);
      end else begin
        exp_mem_q.push_back({1'b1, 32'h300, 32'h1234_5678});
        exp_dm_q.push_back(32'h0);
      end
    end
    @(posedge CLK); #1;
    if_req = 1; if_we = 0; if_addr = 32'h200;
    dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'h1234_5678;
    g = 0;
    for (int i = 0; i < 200 && g < 6; i++) begin
      @(negedge CLK);
      if (if_rdy || dm_rdy) g++;
    end
    chk("cont_grants", 64'(g), 6);
    @(posedge CLK); #1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    wait_idle();

    // read back the written word with a slow response
    @(negedge CLK); resp_delay = 3;
    exp_mem_q.push_back({1'b0, 32'h300, 32'h0});
    exp_dm_q.push_back(32'h1234_5678);
    issue(1, 0, 32'h300, 32'h0);
    wait_idle();
    repeat (2) @(negedge CLK);

    chk("mem_q_drained", 64'(exp_mem_q.size()), 0);
    chk("if_q_drained", 64'(exp_if_q.size()), 0);
    chk("dm_q_drained", 64'(exp_dm_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
